rgb2hsv_pipe: RTL and testbench
===============================

# rgb2hsv_pipe

Parametrised, fully pipelined RGB-to-HSV converter with a valid strobe and a sideband tag. It sits between the camera pixel stream and the colour-tracking logic. It accepts one pixel per cycle at any component width and uses its own fixed-latency divider, so no vendor core is needed. An optional range comparator flags pixels inside a programmable HSV window.

## Interface
Parameters:
- `W`, default 8: component width for r/g/b/h/s/v.
- `USER_W`, default 20: sideband tag width, e.g. pixel x/y, carried alongside the data.

Ports:
- `clock` in, 1: the single clock.
- `reset` in, 1: synchronous reset, active-high.
- `in_valid` in, 1: input pixel strobe.
- `r`, `g`, `b` in, W each: unsigned components.
- `in_user` in, USER_W: tag.
- `out_valid` out, 1: output strobe.
- `h`, `s`, `v` out, W each: results.
- `out_user` out, USER_W: tag, aligned with `h`/`s`/`v`.
- `h_lo`, `h_hi`, `s_min`, `v_min` in, W each: range window. Present only with the macro.
- `in_range` out, 1: window match. Present only with the macro.

## Operation
- Constants: `HUE_G = floor(2^W/3)`, `HUE_B = 2*HUE_G`. For W=8 these are 85 and 170.
- Max and min:
  - `max = max(r,g,b)`, `min = min(r,g,b)`, `delta = max - min`.
  - `v = max`.
- Saturation:
  - `s = floor(delta*(2^W-1)/max)`.
  - If `max==0`, `s = 0`.
- Dominant sector, priority red > green > blue on ties:
  - red: base 0, diff = g - b.
  - green: base HUE_G, diff = b - r.
  - blue: base HUE_B, diff = r - g.
- Hue:
  - `off = floor(|diff|*HUE_G/(2*delta))`.
  - `h = (base + off) mod 2^W` if diff ≥ 0.
  - `h = (base - off) mod 2^W` if diff < 0. This is true modular wrap; red with negative diff gives `2^W - off`.
  - If `delta==0`, `h = 0`.
- Divider sizing: both quotients are < 2^W by construction.
  - Saturation dividend is 2W bits, divisor W bits.
  - Hue dividend is 2W bits, divisor W+1 bits.
- No backpressure. Every `in_valid` sample emerges exactly LAT cycles later. Gaps in `in_valid` propagate as gaps in `out_valid`.
- `h`/`s`/`v`/`out_user` hold their last value while `out_valid` is low.

## Timing
- LAT = W + 4 cycles (12 for W=8). Stages:
  - 1: register inputs.
  - 2: max, min and sector select.
  - 3: delta, dividends, divisors and base.
  - 4 to W+3: one restoring quotient bit per stage, MSB first.
  - W+4: hue add/subtract and wrap, output registers.
- Throughput: one pixel per cycle, back-to-back.
- Reset:
  - Reset values: `out_valid`, `h`, `s`, `v`, `out_user`, `in_range` all 0.
  - The valid shift chain clears.
  - Internal data registers need no reset.
  - Reset mid-stream discards all in-flight pixels. `out_valid` stays 0 until a pixel presented after reset deasserts completes LAT cycles.
  - `in_valid` sampled while `reset` is high is ignored.

## Configuration
- Macro `RGB2HSV_RANGE_EN`.
- When defined:
  - Window ports exist and are sampled in the final stage.
  - `in_range` is registered alongside `h`/`s`/`v`.
  - `in_range = hue_ok && s ≥ s_min && v ≥ v_min`.
  - `hue_ok = (h_lo ≤ h ≤ h_hi)` when `h_lo ≤ h_hi`. Otherwise the window wraps and `hue_ok = (h ≥ h_lo || h ≤ h_hi)`.
- When undefined: window ports and `in_range` are absent, there is no comparator logic, and latency is unchanged.

## Structure
- `rgb2hsv_pkg` holds:
  - functions `hue_g(W)` and `lat(W)`;
  - the sector enum `SEC_R`/`SEC_G`/`SEC_B`.
- One sub-module, `hsv_div_pipe`:
  - parameters W and TAG_W;
  - W-stage pipelined restoring divider with a tag pass-through;
  - instantiated twice, for s and h.
  - Sector base and sign travel as a tag on the hue instance.

## Test plan
All cases use W=8 and LAT=12.
- Primaries: (255,0,0) → h=0,s=255,v=255; (0,255,0) → h=85,s=255,v=255; (0,0,255) → h=170. Each appears exactly 12 cycles after `in_valid`.
- Wrap: (255,0,128) → off=21, h=235, s=255, v=255.
- Degenerate and tie:
  - (100,100,100) → h=0,s=0,v=100.
  - (0,0,0) → all 0.
  - (200,200,50) → red priority, h=42, s=191, v=200.
- Stream: 64 back-to-back random pixels with random `in_valid` gaps → outputs match a reference model bit-exactly, with `out_user` and gap pattern preserved.
- Reset: assert `reset` for 1 cycle with 5 pixels in flight → `out_valid` is 0 for the next 12 cycles, then a new pixel emerges correctly.
- Macro: `h_lo=230`, `h_hi=10`, `s_min=128`, `v_min=64`:
  - (255,0,128) → `in_range=1`.
  - (0,255,0) → `in_range=0`.
  - (40,40,40) → `in_range=0`.

Source files
------------

// File: rtl/rgb2hsv_pkg.sv
// Shared types and sizing helpers for the RGB-to-HSV pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Used by rgb2hsv_pipe and hsv_div_pipe.
package rgb2hsv_pkg;

    typedef enum logic [1:0] {
        SEC_R,
        SEC_G,
        SEC_B
    } sector_e;

    function automatic int hue_g(input int w);
        return (1 << w) / 3;
    endfunction

    function automatic int lat(input int w);
        return w + 4;
    endfunction

endpackage

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring divider (2W / W+1 -> W-bit quotient) with tag pass-through.
// Latency: W cycles, one quotient bit per stage, MSB first.
// Backpressure: none; accepts one operand pair per cycle.
module hsv_div_pipe #(
    parameter int W     = 8,
    parameter int TAG_W = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [2*W-1:0]     dividend,
    input  logic [W:0]         divisor,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [W-1:0]       quotient,
    output logic [TAG_W-1:0]   out_tag
);

    logic             vld_q [W];
    logic             vld_d [W];
    logic [W:0]       rem_q [W];
    logic [W:0]       rem_d [W];
    logic [W:0]       dvs_q [W];
    logic [W:0]       dvs_d [W];
    logic [W-1:0]     low_q [W];
    logic [W-1:0]     low_d [W];
    logic [W-1:0]     quo_q [W];
    logic [W-1:0]     quo_d [W];
    logic [TAG_W-1:0] tag_q [W];
    logic [TAG_W-1:0] tag_d [W];

    logic             p_vld [W];
    logic [W:0]       p_rem [W];
    logic [W:0]       p_dvs [W];
    logic [W-1:0]     p_low [W];
    logic [W-1:0]     p_quo [W];
    logic [TAG_W-1:0] p_tag [W];
    logic [W+1:0]     trial [W];
    logic [W+1:0]     diff  [W];
    logic             take  [W];

    // Quotient fits W bits, so the dividend's upper half is already below the divisor.
    always_comb begin
        p_vld[0] = in_valid;
        p_rem[0] = {1'b0, dividend[2*W-1:W]};
        p_low[0] = dividend[W-1:0];
        p_quo[0] = '0;
        p_dvs[0] = divisor;
        p_tag[0] = in_tag;
        for (int k = 1; k < W; k++) begin
            p_vld[k] = vld_q[k-1];
            p_rem[k] = rem_q[k-1];
            p_low[k] = low_q[k-1];
            p_quo[k] = quo_q[k-1];
            p_dvs[k] = dvs_q[k-1];
            p_tag[k] = tag_q[k-1];
        end
        for (int k = 0; k < W; k++) begin
            trial[k] = {p_rem[k], p_low[k][W-1]};
            diff[k]  = trial[k] - {1'b0, p_dvs[k]};
            take[k]  = trial[k] >= {1'b0, p_dvs[k]};
            rem_d[k] = take[k] ? diff[k][W:0] : trial[k][W:0];
            quo_d[k] = (p_quo[k] << 1) | W'(take[k]);
            low_d[k] = p_low[k] << 1;
            dvs_d[k] = p_dvs[k];
            tag_d[k] = p_tag[k];
            vld_d[k] = p_vld[k];
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < W; k++) begin
            if (reset) begin
                vld_q[k] <= 1'b0;
            end else begin
                vld_q[k] <= vld_d[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < W; k++) begin
            rem_q[k] <= rem_d[k];
            low_q[k] <= low_d[k];
            quo_q[k] <= quo_d[k];
            dvs_q[k] <= dvs_d[k];
            tag_q[k] <= tag_d[k];
        end
    end

    assign out_valid = vld_q[W-1];
    assign quotient  = quo_q[W-1];
    assign out_tag   = tag_q[W-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// RGB-to-HSV converter with tag sideband; RGB2HSV_RANGE_EN adds an HSV window match.
// Latency: W+4 cycles, one pixel per cycle.
// Backpressure: none; in_valid gaps propagate unchanged to out_valid.
module rgb2hsv_pipe
    import rgb2hsv_pkg::*;
#(
    parameter int W      = 8,
    parameter int USER_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [W-1:0]      r,
    input  logic [W-1:0]      g,
    input  logic [W-1:0]      b,
    input  logic [USER_W-1:0] in_user,
`ifdef RGB2HSV_RANGE_EN
    input  logic [W-1:0]      h_lo,
    input  logic [W-1:0]      h_hi,
    input  logic [W-1:0]      s_min,
    input  logic [W-1:0]      v_min,
    output logic              in_range,
`endif
    output logic              out_valid,
    output logic [W-1:0]      h,
    output logic [W-1:0]      s,
    output logic [W-1:0]      v,
    output logic [USER_W-1:0] out_user
);

    localparam logic [W-1:0] HUE_G = W'(hue_g(W));
    localparam logic [W-1:0] HUE_B = W'(2 * hue_g(W));

    logic              vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
    logic [W-1:0]      r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic [W-1:0]      r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic [USER_W-1:0] user1_q, user1_d, user2_q, user2_d, user3_q, user3_d;
    logic [W-1:0]      max2_q, max2_d, min2_q, min2_d, max3_q, max3_d;
    sector_e           sec2_q, sec2_d;
    logic [2*W-1:0]    s_dvd3_q, s_dvd3_d, h_dvd3_q, h_dvd3_d;
    logic [W:0]        s_dvs3_q, s_dvs3_d, h_dvs3_q, h_dvs3_d;
    logic [W-1:0]      base3_q, base3_d;
    logic              neg3_q, neg3_d;
    logic [W-1:0]      delta, dif_a, dif_b, abs_dif;

    logic              s_div_vld, h_div_vld, fin_vld;
    logic [W-1:0]      s_quo, h_quo;
    logic [W+USER_W-1:0] s_tag;
    logic [W:0]        h_tag;
    logic [W-1:0]      h_new;

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      h_q, h_d, s_q, s_d, v_q, v_d;
    logic [USER_W-1:0] user_q, user_d;

    always_comb begin
        vld1_d  = in_valid;
        r1_d    = r;
        g1_d    = g;
        b1_d    = b;
        user1_d = in_user;

        vld2_d  = vld1_q;
        r2_d    = r1_q;
        g2_d    = g1_q;
        b2_d    = b1_q;
        user2_d = user1_q;
        if (r1_q >= g1_q && r1_q >= b1_q) begin
            sec2_d = SEC_R;
            max2_d = r1_q;
        end else if (g1_q >= b1_q) begin
            sec2_d = SEC_G;
            max2_d = g1_q;
        end else begin
            sec2_d = SEC_B;
            max2_d = b1_q;
        end
        min2_d = r1_q;
        if (g1_q < min2_d) min2_d = g1_q;
        if (b1_q < min2_d) min2_d = b1_q;

        vld3_d  = vld2_q;
        user3_d = user2_q;
        max3_d  = max2_q;
        delta   = max2_q - min2_q;
        case (sec2_q)
            SEC_R: begin
                dif_a   = g2_q;
                dif_b   = b2_q;
                base3_d = '0;
            end
            SEC_G: begin
                dif_a   = b2_q;
                dif_b   = r2_q;
                base3_d = HUE_G;
            end
            default: begin
                dif_a   = r2_q;
                dif_b   = g2_q;
                base3_d = HUE_B;
            end
        endcase
        neg3_d  = dif_a < dif_b;
        abs_dif = neg3_d ? (dif_b - dif_a) : (dif_a - dif_b);
        // Zero divisors only occur with a zero dividend; divide by 1 to get a zero quotient.
        s_dvd3_d = {delta, {W{1'b0}}} - {{W{1'b0}}, delta};
        s_dvs3_d = (max2_q == '0) ? {{W{1'b0}}, 1'b1} : {1'b0, max2_q};
        h_dvd3_d = {{W{1'b0}}, abs_dif} * {{W{1'b0}}, HUE_G};
        h_dvs3_d = (delta == '0) ? {{W{1'b0}}, 1'b1} : {delta, 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
        end else begin
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            vld3_q <= vld3_d;
        end
    end

    always_ff @(posedge clock) begin
        r1_q     <= r1_d;
        g1_q     <= g1_d;
        b1_q     <= b1_d;
        user1_q  <= user1_d;
        r2_q     <= r2_d;
        g2_q     <= g2_d;
        b2_q     <= b2_d;
        user2_q  <= user2_d;
        max2_q   <= max2_d;
        min2_q   <= min2_d;
        sec2_q   <= sec2_d;
        user3_q  <= user3_d;
        max3_q   <= max3_d;
        base3_q  <= base3_d;
        neg3_q   <= neg3_d;
        s_dvd3_q <= s_dvd3_d;
        s_dvs3_q <= s_dvs3_d;
        h_dvd3_q <= h_dvd3_d;
        h_dvs3_q <= h_dvs3_d;
    end

    hsv_div_pipe #(.W(W), .TAG_W(W + USER_W)) u_s_div (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (vld3_q),
        .dividend  (s_dvd3_q),
        .divisor   (s_dvs3_q),
        .in_tag    ({max3_q, user3_q}),
        .out_valid (s_div_vld),
        .quotient  (s_quo),
        .out_tag   (s_tag)
    );

    hsv_div_pipe #(.W(W), .TAG_W(W + 1)) u_h_div (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (vld3_q),
        .dividend  (h_dvd3_q),
        .divisor   (h_dvs3_q),
        .in_tag    ({base3_q, neg3_q}),
        .out_valid (h_div_vld),
        .quotient  (h_quo),
        .out_tag   (h_tag)
    );

    always_comb begin
        fin_vld     = s_div_vld && h_div_vld;
        // W-bit arithmetic gives the modular hue wrap for free.
        h_new       = h_tag[0] ? (h_tag[W:1] - h_quo) : (h_tag[W:1] + h_quo);
        out_valid_d = fin_vld;
        h_d         = fin_vld ? h_new : h_q;
        s_d         = fin_vld ? s_quo : s_q;
        v_d         = fin_vld ? s_tag[W+USER_W-1:USER_W] : v_q;
        user_d      = fin_vld ? s_tag[USER_W-1:0] : user_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            h_q         <= '0;
            s_q         <= '0;
            v_q         <= '0;
            user_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            h_q         <= h_d;
            s_q         <= s_d;
            v_q         <= v_d;
            user_q      <= user_d;
        end
    end

    assign out_valid = out_valid_q;
    assign h         = h_q;
    assign s         = s_q;
    assign v         = v_q;
    assign out_user  = user_q;

`ifdef RGB2HSV_RANGE_EN
    logic in_range_q, in_range_d, hue_ok;

    always_comb begin
        if (h_lo <= h_hi) begin
            hue_ok = (h_new >= h_lo) && (h_new <= h_hi);
        end else begin
            hue_ok = (h_new >= h_lo) || (h_new <= h_hi);
        end
        in_range_d = fin_vld ? (hue_ok && (s_quo >= s_min) &&
                                (s_tag[W+USER_W-1:USER_W] >= v_min)) : in_range_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_range_q <= 1'b0;
        end else begin
            in_range_q <= in_range_d;
        end
    end

    assign in_range = in_range_q;
`endif

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Directed and randomised checks for rgb2hsv_pipe at W=8.
`timescale 1ns/1ps
module tb_rgb2hsv_pipe;
    import rgb2hsv_pkg::*;

    localparam int W   = 8;
    localparam int UW  = 20;
    localparam int LAT = lat(W);

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  r = '0, g = '0, b = '0;
    logic [UW-1:0] in_user = '0;
    logic          out_valid;
    logic [W-1:0]  h, s, v;
    logic [UW-1:0] out_user;
`ifdef RGB2HSV_RANGE_EN
    logic [W-1:0]  h_lo = 8'd230, h_hi = 8'd10, s_min = 8'd128, v_min = 8'd64;
    logic          in_range;
    logic          cap_rng;
`endif

    int checks = 0;
    int errors = 0;

    int            cap_lat;
    logic [W-1:0]  cap_h, cap_s, cap_v;
    logic [UW-1:0] cap_u;

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] eh, es, ev;
    } vec_t;
    vec_t tbl[10];

    logic          dv [256];
    logic [7:0]    dr [256], dg [256], db [256];
    logic [UW-1:0] du [256];

    always #5 clock = ~clock;

    rgb2hsv_pipe #(.W(W), .USER_W(UW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .r         (r),
        .g         (g),
        .b         (b),
        .in_user   (in_user),
`ifdef RGB2HSV_RANGE_EN
        .h_lo      (h_lo),
        .h_hi      (h_hi),
        .s_min     (s_min),
        .v_min     (v_min),
        .in_range  (in_range),
`endif
        .out_valid (out_valid),
        .h         (h),
        .s         (s),
        .v         (v),
        .out_user  (out_user)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input int rr, input int gg, input int bb,
                                  output int hh, output int ss, output int vv);
        int mx, mn, d, base, dif, off;
        mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
        mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
        d  = mx - mn;
        vv = mx;
        ss = (mx == 0) ? 0 : (d * 255) / mx;
        if (rr >= gg && rr >= bb) begin base = 0;   dif = gg - bb; end
        else if (gg >= bb)        begin base = 85;  dif = bb - rr; end
        else                      begin base = 170; dif = rr - gg; end
        if (d == 0) begin
            hh = 0;
        end else begin
            off = ((dif < 0 ? -dif : dif) * 85) / (2 * d);
            hh  = (dif >= 0) ? (base + off) % 256 : (base - off + 256) % 256;
        end
    endfunction

    // Call at a negedge; returns at the negedge the result appears (or after the bound).
    task automatic run_one(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                           input logic [UW-1:0] uu);
        r = rr; g = gg; b = bb; in_user = uu; in_valid = 1'b1;
        cap_lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (out_valid) begin
                cap_lat = c;
                cap_h = h; cap_s = s; cap_v = v; cap_u = out_user;
`ifdef RGB2HSV_RANGE_EN
                cap_rng = in_range;
`endif
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ncyc, eh, es, ev, exp_n;
        logic [W-1:0]  lh, ls, lv;
        logic [UW-1:0] lu;
        logic expv;

        tbl[0] = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd255, 8'd255};
        tbl[1] = '{8'd0,   8'd255, 8'd0,   8'd85,  8'd255, 8'd255};
        tbl[2] = '{8'd0,   8'd0,   8'd255, 8'd170, 8'd255, 8'd255};
        tbl[3] = '{8'd255, 8'd0,   8'd128, 8'd235, 8'd255, 8'd255};
        tbl[4] = '{8'd100, 8'd100, 8'd100, 8'd0,   8'd0,   8'd100};
        tbl[5] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        tbl[6] = '{8'd200, 8'd200, 8'd50,  8'd42,  8'd191, 8'd200};
        tbl[7] = '{8'd255, 8'd255, 8'd0,   8'd42,  8'd255, 8'd255};
        tbl[8] = '{8'd0,   8'd255, 8'd255, 8'd127, 8'd255, 8'd255};
        tbl[9] = '{8'd10,  8'd20,  8'd30,  8'd149, 8'd170, 8'd30};

        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_h", h, 0);
        chk("rst_s", s, 0);
        chk("rst_v", v, 0);
        chk("rst_user", out_user, 0);
`ifdef RGB2HSV_RANGE_EN
        chk("rst_in_range", in_range, 0);
`endif
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_one(tbl[i].r, tbl[i].g, tbl[i].b, UW'(32'h100 + i));
            chk($sformatf("vec%0d_lat", i), cap_lat, LAT);
            chk($sformatf("vec%0d_h", i), cap_h, tbl[i].eh);
            chk($sformatf("vec%0d_s", i), cap_s, tbl[i].es);
            chk($sformatf("vec%0d_v", i), cap_v, tbl[i].ev);
            chk($sformatf("vec%0d_user", i), cap_u, 32'h100 + i);
            repeat (2) @(negedge clock);
        end

`ifdef RGB2HSV_RANGE_EN
        run_one(8'd255, 8'd0, 8'd128, UW'(1));
        chk("rng_wrap_in", cap_rng, 1);
        run_one(8'd0, 8'd255, 8'd0, UW'(2));
        chk("rng_green_out", cap_rng, 0);
        run_one(8'd40, 8'd40, 8'd40, UW'(3));
        chk("rng_grey_out", cap_rng, 0);
        chk("rng_grey_h", cap_h, 0);
        @(negedge clock);
`endif

        // Random stream with gaps; output at cycle c mirrors input at c-LAT.
        n = 0;
        ncyc = 0;
        while (n < 64 && ncyc < 256) begin
            dv[ncyc] = ($urandom_range(0, 3) != 0);
            dr[ncyc] = 8'($urandom_range(0, 255));
            dg[ncyc] = 8'($urandom_range(0, 255));
            db[ncyc] = 8'($urandom_range(0, 255));
            du[ncyc] = UW'($urandom);
            if (dv[ncyc]) n++;
            ncyc++;
        end
        lh = cap_h; ls = cap_s; lv = cap_v; lu = cap_u;
        exp_n = 0;
        for (int c = 0; c < ncyc + LAT + 2; c++) begin
            expv = (c >= LAT && c - LAT < ncyc) ? dv[c-LAT] : 1'b0;
            chk("str_valid", out_valid, expv);
            if (expv) begin
                model(dr[c-LAT], dg[c-LAT], db[c-LAT], eh, es, ev);
                lh = W'(eh); ls = W'(es); lv = W'(ev); lu = du[c-LAT];
                exp_n++;
            end
            chk("str_h", h, lh);
            chk("str_s", s, ls);
            chk("str_v", v, lv);
            chk("str_user", out_user, lu);
            if (c < ncyc) begin
                in_valid = dv[c]; r = dr[c]; g = dg[c]; b = db[c]; in_user = du[c];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        chk("str_count", exp_n, 64);

        // Mid-stream reset: five pixels in flight plus one offered during reset.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; r = 8'd255; g = 8'(i * 40); b = 8'd0; in_user = UW'(i);
            @(negedge clock);
        end
        in_valid = 1'b1; r = 8'd7; g = 8'd9; b = 8'd11; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_h", h, 0);
        chk("mid_rst_user", out_user, 0);
        r = 8'd255; g = 8'd0; b = 8'd128; in_user = UW'(20'hABCDE); in_valid = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (c < LAT) begin
                chk($sformatf("mid_rst_quiet%0d", c), out_valid, 0);
            end else begin
                chk("mid_rst_new_valid", out_valid, 1);
                chk("mid_rst_new_h", h, 235);
                chk("mid_rst_new_s", s, 255);
                chk("mid_rst_new_v", v, 255);
                chk("mid_rst_new_user", out_user, 20'hABCDE);
            end
        end
        @(negedge clock);
        chk("mid_rst_single", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
